// File: rtl/sc_datapath_pkg.sv
// sc_datapath_pkg: shared widths, constants and helpers for the SC datapath.
package sc_datapath_pkg;

   localparam int DATAWIDTH_BUS                  = 8;
   localparam int DATAWIDTH_DECODER_SELECTION    = 3;
   localparam int DATAWIDTH_MUX_SELECTION        = 3;
   localparam int DATAWIDTH_ALU_SELECTION        = 4;
   localparam int DATAWIDTH_REGSHIFTER_SELECTION = 2;

   localparam logic [7:0] DATA_FIXED_REGFIX0 = 8'd0;
   localparam logic [7:0] DATA_FIXED_REGFIX1 = 8'd1;

   // ALU opcodes; every code not listed passes BUSA through
   localparam logic [3:0] ALU_BUSA = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_NOTA = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_ADD  = 4'b1000;
   localparam logic [3:0] ALU_SUB  = 4'b1001;
   localparam logic [3:0] ALU_INC  = 4'b1010;
   localparam logic [3:0] ALU_DEC  = 4'b1011;

   // BUSA/BUSB source codes; 110/111 read as zero
   localparam logic [2:0] MUX_GENREG0 = 3'b000;
   localparam logic [2:0] MUX_GENREG1 = 3'b001;
   localparam logic [2:0] MUX_GENREG2 = 3'b010;
   localparam logic [2:0] MUX_GENREG3 = 3'b011;
   localparam logic [2:0] MUX_REGFIX0 = 3'b100;
   localparam logic [2:0] MUX_REGFIX1 = 3'b101;
   localparam logic [2:0] MUX_ZERO    = 3'b110;

   // Clear/load decoder code that selects no register
   localparam logic [2:0] DEC_NONE = 3'b111;

   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;

   // Active-low status flags as returned to the control unit
   typedef struct packed {
      logic overflow_n;
      logic carry_n;
      logic negative_n;
      logic zero_n;
   } flags_t;

   // Signed overflow of a + b = s: operands agree in sign, result does not
   function automatic logic fn_add_overflow(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] s);
      return (a[7] == b[7]) && (s[7] != a[7]);
   endfunction

endpackage

// File: rtl/sc_datapath_alu.sv
// sc_datapath_alu: combinational ALU; all arithmetic shares one 9-bit adder.
module sc_datapath_alu
   import sc_datapath_pkg::*;
(
   input  logic [DATAWIDTH_BUS-1:0]           i_a,
   input  logic [DATAWIDTH_BUS-1:0]           i_b,
   input  logic [DATAWIDTH_ALU_SELECTION-1:0] i_sel,
   output logic [DATAWIDTH_BUS-1:0]           o_r,
   output logic                               o_carry,
   output logic                               o_overflow
);

   logic [7:0] w_op_b;
   logic       w_cin;
   logic       w_arith;
   logic [8:0] w_sum;

   // Select the second adder operand and carry-in for ADD/SUB/INC/DEC
   always_comb begin
      w_op_b  = i_b;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      case (i_sel)
         ALU_ADD: begin w_op_b = i_b;   w_cin = 1'b0; w_arith = 1'b1; end
         ALU_SUB: begin w_op_b = ~i_b;  w_cin = 1'b1; w_arith = 1'b1; end
         ALU_INC: begin w_op_b = 8'h00; w_cin = 1'b1; w_arith = 1'b1; end
         ALU_DEC: begin w_op_b = 8'hFF; w_cin = 1'b0; w_arith = 1'b1; end
         default: begin w_op_b = i_b;   w_cin = 1'b0; w_arith = 1'b0; end
      endcase
   end

   assign w_sum = {1'b0, i_a} + {1'b0, w_op_b} + {8'd0, w_cin};

   // Result selection; unused opcodes pass BUSA
   always_comb begin
      o_r = i_a;
      case (i_sel)
         ALU_BUSA: o_r = i_a;
         ALU_OR:   o_r = i_a | i_b;
         ALU_AND:  o_r = i_a & i_b;
         ALU_NOTA: o_r = ~i_a;
         ALU_XOR:  o_r = i_a ^ i_b;
         ALU_ADD,
         ALU_SUB,
         ALU_INC,
         ALU_DEC:  o_r = w_sum[7:0];
         default:  o_r = i_a;
      endcase
   end

   // Carry/overflow are meaningful only for adder operations
   always_comb begin
      if (w_arith) begin
         o_carry    = w_sum[8];
         o_overflow = fn_add_overflow(i_a, w_op_b, w_sum[7:0]);
      end else begin
         o_carry    = 1'b0;
         o_overflow = 1'b0;
      end
   end

endmodule

// File: rtl/sc_datapath.sv
// sc_datapath: register file, read muxes, ALU, shifter (BUSC) and status flags.
module sc_datapath
   import sc_datapath_pkg::*;
(
   input  logic                                      SC_DATAPATH_CLOCK_50,
   input  logic                                      SC_DATAPATH_RESET_InHigh,
   input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderclearselection_InBUS,
   input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderloadselection_InBUS,
   input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSA_InBUS,
   input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSB_InBUS,
   input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DATAPATH_aluselection_InBUS,
   input  logic                                      SC_DATAPATH_regSHIFTERclear_InLow,
   input  logic                                      SC_DATAPATH_regSHIFTERload_InLow,
   input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DATAPATH_regSHIFTERshiftselection_InLow,
   output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_BUSC_OutBUS,
   output logic                                      SC_DATAPATH_overflow_OutLow,
   output logic                                      SC_DATAPATH_carry_OutLow,
   output logic                                      SC_DATAPATH_negative_OutLow,
   output logic                                      SC_DATAPATH_zero_OutLow
);

   logic [3:0][7:0] r_genreg;
   logic [7:0]      r_shifter;
   flags_t          r_flags;

   logic [7:0]      w_busa;
   logic [7:0]      w_busb;
   logic [7:0]      w_alu_r;
   logic            w_alu_carry;
   logic            w_alu_overflow;

   // Source selection shared by BUSA and BUSB
   function automatic logic [7:0] fn_mux_read(input logic [2:0]      sel,
                                              input logic [3:0][7:0] regs);
      logic [7:0] v;
      case (sel)
         MUX_GENREG0: v = regs[0];
         MUX_GENREG1: v = regs[1];
         MUX_GENREG2: v = regs[2];
         MUX_GENREG3: v = regs[3];
         MUX_REGFIX0: v = DATA_FIXED_REGFIX0;
         MUX_REGFIX1: v = DATA_FIXED_REGFIX1;
         default:     v = 8'd0;
      endcase
      return v;
   endfunction

   assign w_busa = fn_mux_read(SC_DATAPATH_muxselectionBUSA_InBUS, r_genreg);
   assign w_busb = fn_mux_read(SC_DATAPATH_muxselectionBUSB_InBUS, r_genreg);

   sc_datapath_alu u_alu (
      .i_a        (w_busa),
      .i_b        (w_busb),
      .i_sel      (SC_DATAPATH_aluselection_InBUS),
      .o_r        (w_alu_r),
      .o_carry    (w_alu_carry),
      .o_overflow (w_alu_overflow)
   );

   // Shifter: clear > load > shift > hold, one action per edge
   always_ff @(posedge SC_DATAPATH_CLOCK_50 or posedge SC_DATAPATH_RESET_InHigh) begin
      if (SC_DATAPATH_RESET_InHigh) begin
         r_shifter <= 8'd0;
      end else if (!SC_DATAPATH_regSHIFTERclear_InLow) begin
         r_shifter <= 8'd0;
      end else if (!SC_DATAPATH_regSHIFTERload_InLow) begin
         r_shifter <= w_alu_r;
      end else begin
         case (SC_DATAPATH_regSHIFTERshiftselection_InLow)
            SHIFT_LEFT:  r_shifter <= {r_shifter[6:0], 1'b0};
            SHIFT_RIGHT: r_shifter <= {1'b0, r_shifter[7:1]};
            default:     r_shifter <= r_shifter;
         endcase
      end
   end

   // Flags follow the ALU only on an effective shifter load (not under clear)
   always_ff @(posedge SC_DATAPATH_CLOCK_50 or posedge SC_DATAPATH_RESET_InHigh) begin
      if (SC_DATAPATH_RESET_InHigh) begin
         r_flags <= 4'b1111;
      end else if (SC_DATAPATH_regSHIFTERclear_InLow && !SC_DATAPATH_regSHIFTERload_InLow) begin
         r_flags.overflow_n <= ~w_alu_overflow;
         r_flags.carry_n    <= ~w_alu_carry;
         r_flags.negative_n <= ~w_alu_r[7];
         r_flags.zero_n     <= (w_alu_r != 8'd0);
      end else begin
         r_flags <= r_flags;
      end
   end

   // General registers: per register, clear beats load; load takes pre-edge BUSC
   always_ff @(posedge SC_DATAPATH_CLOCK_50 or posedge SC_DATAPATH_RESET_InHigh) begin
      if (SC_DATAPATH_RESET_InHigh) begin
         r_genreg <= {4{8'd0}};
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (SC_DATAPATH_decoderclearselection_InBUS == n[2:0]) begin
               r_genreg[n] <= 8'd0;
            end else if (SC_DATAPATH_decoderloadselection_InBUS == n[2:0]) begin
               r_genreg[n] <= r_shifter;
            end else begin
               r_genreg[n] <= r_genreg[n];
            end
         end
      end
   end

   assign SC_DATAPATH_BUSC_OutBUS     = r_shifter;
   assign SC_DATAPATH_overflow_OutLow = r_flags.overflow_n;
   assign SC_DATAPATH_carry_OutLow    = r_flags.carry_n;
   assign SC_DATAPATH_negative_OutLow = r_flags.negative_n;
   assign SC_DATAPATH_zero_OutLow     = r_flags.zero_n;

endmodule

// File: tb/tb_sc_datapath.sv
// tb_sc_datapath: directed self-checking bench for sc_datapath.
module tb_sc_datapath;
   import sc_datapath_pkg::*;

   logic       clk;
   logic       rst;
   logic [2:0] clrsel;
   logic [2:0] ldsel;
   logic [2:0] ma;
   logic [2:0] mb;
   logic [3:0] alu;
   logic       sh_clr_n;
   logic       sh_ld_n;
   logic [1:0] sh;
   logic [7:0] busc;
   logic       ov_n;
   logic       c_n;
   logic       n_n;
   logic       z_n;
   logic [3:0] flags;

   int n_tests = 0;
   int n_fail  = 0;

   assign flags = {ov_n, c_n, n_n, z_n};

   sc_datapath dut (
      .SC_DATAPATH_CLOCK_50                       (clk),
      .SC_DATAPATH_RESET_InHigh                   (rst),
      .SC_DATAPATH_decoderclearselection_InBUS    (clrsel),
      .SC_DATAPATH_decoderloadselection_InBUS     (ldsel),
      .SC_DATAPATH_muxselectionBUSA_InBUS         (ma),
      .SC_DATAPATH_muxselectionBUSB_InBUS         (mb),
      .SC_DATAPATH_aluselection_InBUS             (alu),
      .SC_DATAPATH_regSHIFTERclear_InLow          (sh_clr_n),
      .SC_DATAPATH_regSHIFTERload_InLow           (sh_ld_n),
      .SC_DATAPATH_regSHIFTERshiftselection_InLow (sh),
      .SC_DATAPATH_BUSC_OutBUS                    (busc),
      .SC_DATAPATH_overflow_OutLow                (ov_n),
      .SC_DATAPATH_carry_OutLow                   (c_n),
      .SC_DATAPATH_negative_OutLow                (n_n),
      .SC_DATAPATH_zero_OutLow                    (z_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      clrsel = DEC_NONE; ldsel = DEC_NONE; ma = MUX_ZERO; mb = MUX_ZERO;
      alu = ALU_BUSA; sh_clr_n = 1'b1; sh_ld_n = 1'b1; sh = 2'b00;
   endtask

   // Drive one control word for one clock, sample point is 1 time unit after the edge
   task automatic cyc(input logic [2:0] c_sel, input logic [2:0] l_sel,
                      input logic [2:0] a_sel, input logic [2:0] b_sel,
                      input logic [3:0] op, input logic clr_n, input logic ld_n,
                      input logic [1:0] shift);
      clrsel = c_sel; ldsel = l_sel; ma = a_sel; mb = b_sel;
      alu = op; sh_clr_n = clr_n; sh_ld_n = ld_n; sh = shift;
      @(posedge clk);
      #1;
      idle();
   endtask

   // Build an arbitrary value in GenREG_n by doubling and incrementing
   task automatic set_reg(input logic [2:0] n, input logic [7:0] v);
      cyc(n, DEC_NONE, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
      for (int i = 7; i >= 0; i--) begin
         cyc(DEC_NONE, DEC_NONE, n, n, ALU_ADD, 1'b1, 1'b0, 2'b00);
         cyc(DEC_NONE, n, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
         if (v[i]) begin
            cyc(DEC_NONE, DEC_NONE, n, MUX_ZERO, ALU_INC, 1'b1, 1'b0, 2'b00);
            cyc(DEC_NONE, n, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
         end
      end
   endtask

   // Copy GenREG_n into the shifter and return BUSC
   task automatic read_reg(input logic [2:0] n, output logic [7:0] v);
      cyc(DEC_NONE, DEC_NONE, n, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, 2'b00);
      v = busc;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_tests++; if (busc !== 8'h00) begin n_fail++; $display("FAIL reset_busc: got %h expected 00", busc); end
      n_tests++; if (flags !== 4'b1111) begin n_fail++; $display("FAIL reset_flags: got %b expected 1111", flags); end
      // Mid-sequence asynchronous reset
      set_reg(3'd1, 8'h05);
      set_reg(3'd0, 8'hAA);
      n_tests++; if (busc !== 8'hAA) begin n_fail++; $display("FAIL pre_reset_busc: got %h expected aa", busc); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (busc !== 8'h00) begin n_fail++; $display("FAIL async_reset_busc: got %h expected 00", busc); end
      n_tests++; if (flags !== 4'b1111) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 1111", flags); end
      #1 rst = 1'b0;
      read_reg(3'd1, v);
      n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL async_reset_genreg1: got %h expected 00", v); end
   endtask

   task automatic test_fix_shift();
      logic [7:0] v;
      cyc(DEC_NONE, DEC_NONE, MUX_REGFIX0, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, 2'b00);
      n_tests++; if (flags !== 4'b1110) begin n_fail++; $display("FAIL regfix0_flags: got %b expected 1110", flags); end
      cyc(DEC_NONE, DEC_NONE, MUX_REGFIX1, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
      n_tests++; if (busc !== 8'h00) begin n_fail++; $display("FAIL fix_cycle1_busc: got %h expected 00", busc); end
      cyc(DEC_NONE, DEC_NONE, MUX_REGFIX1, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, 2'b00);
      n_tests++; if (busc !== 8'h01) begin n_fail++; $display("FAIL fix_load_busc: got %h expected 01", busc); end
      n_tests++; if (flags !== 4'b1111) begin n_fail++; $display("FAIL fix_load_flags: got %b expected 1111", flags); end
      cyc(DEC_NONE, DEC_NONE, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, SHIFT_LEFT);
      n_tests++; if (busc !== 8'h02) begin n_fail++; $display("FAIL fix_shift_busc: got %h expected 02", busc); end
      cyc(DEC_NONE, 3'b010, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
      read_reg(3'd2, v);
      n_tests++; if (v !== 8'h02) begin n_fail++; $display("FAIL fix_genreg2: got %h expected 02", v); end
   endtask

   task automatic test_add_flags();
      set_reg(3'd0, 8'h7F);
      set_reg(3'd1, 8'h01);
      cyc(DEC_NONE, DEC_NONE, 3'd0, 3'd1, ALU_ADD, 1'b1, 1'b0, 2'b00);
      n_tests++; if (busc !== 8'h80) begin n_fail++; $display("FAIL add_busc: got %h expected 80", busc); end
      n_tests++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL add_flags: got %b expected 0101", flags); end
   endtask

   task automatic test_sub_dec();
      set_reg(3'd0, 8'h05);
      cyc(DEC_NONE, DEC_NONE, 3'd0, 3'd0, ALU_SUB, 1'b1, 1'b0, 2'b00);
      n_tests++; if (busc !== 8'h00) begin n_fail++; $display("FAIL sub_busc: got %h expected 00", busc); end
      n_tests++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL sub_flags: got %b expected 1010", flags); end
      cyc(3'd3, DEC_NONE, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
      cyc(DEC_NONE, DEC_NONE, 3'd3, MUX_ZERO, ALU_DEC, 1'b1, 1'b0, 2'b00);
      n_tests++; if (busc !== 8'hFF) begin n_fail++; $display("FAIL dec_busc: got %h expected ff", busc); end
      n_tests++; if (flags !== 4'b1101) begin n_fail++; $display("FAIL dec_flags: got %b expected 1101", flags); end
   endtask

   task automatic test_logic();
      // GenREG_0 = 05, GenREG_1 = 01 here
      logic [3:0] ops [6];
      logic [7:0] exp [6];
      ops = '{ALU_OR, ALU_AND, ALU_XOR, ALU_NOTA, 4'b0101, 4'b1111};
      exp = '{8'h05, 8'h01, 8'h04, 8'hFA, 8'h05, 8'h05};
      for (int i = 0; i < 6; i++) begin
         cyc(DEC_NONE, DEC_NONE, 3'd0, 3'd1, ops[i], 1'b1, 1'b0, 2'b00);
         n_tests++;
         if (busc !== exp[i]) begin
            n_fail++; $display("FAIL logic_op%b: got %h expected %h", ops[i], busc, exp[i]);
         end
         n_tests++;
         if (flags[3:2] !== 2'b11) begin
            n_fail++; $display("FAIL logic_ovc_op%b: got %b expected 11", ops[i], flags[3:2]);
         end
      end
      cyc(DEC_NONE, DEC_NONE, 3'b111, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, 2'b00);
      n_tests++; if (busc !== 8'h00) begin n_fail++; $display("FAIL mux111_busc: got %h expected 00", busc); end
   endtask

   task automatic test_shift();
      set_reg(3'd0, 8'h81);
      cyc(DEC_NONE, DEC_NONE, 3'd0, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, 2'b00);
      cyc(DEC_NONE, DEC_NONE, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, SHIFT_RIGHT);
      n_tests++; if (busc !== 8'h40) begin n_fail++; $display("FAIL shr_busc: got %h expected 40", busc); end
      cyc(DEC_NONE, DEC_NONE, 3'd0, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, 2'b00);
      cyc(DEC_NONE, DEC_NONE, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, SHIFT_LEFT);
      n_tests++; if (busc !== 8'h02) begin n_fail++; $display("FAIL shl1_busc: got %h expected 02", busc); end
      cyc(DEC_NONE, DEC_NONE, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, SHIFT_LEFT);
      n_tests++; if (busc !== 8'h04) begin n_fail++; $display("FAIL shl2_busc: got %h expected 04", busc); end
      cyc(DEC_NONE, DEC_NONE, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b11);
      n_tests++; if (busc !== 8'h04) begin n_fail++; $display("FAIL hold11_busc: got %h expected 04", busc); end
      cyc(DEC_NONE, DEC_NONE, 3'd0, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, SHIFT_LEFT);
      n_tests++; if (busc !== 8'h81) begin n_fail++; $display("FAIL load_vs_shift_busc: got %h expected 81", busc); end
      n_tests++; if (flags !== 4'b1101) begin n_fail++; $display("FAIL load_vs_shift_flags: got %b expected 1101", flags); end
      cyc(DEC_NONE, DEC_NONE, MUX_REGFIX0, MUX_ZERO, ALU_BUSA, 1'b0, 1'b0, 2'b00);
      n_tests++; if (busc !== 8'h00) begin n_fail++; $display("FAIL clear_vs_load_busc: got %h expected 00", busc); end
      n_tests++; if (flags !== 4'b1101) begin n_fail++; $display("FAIL clear_keeps_flags: got %b expected 1101", flags); end
   endtask

   task automatic test_clr_ld();
      logic [7:0] v;
      set_reg(3'd3, 8'h12);
      set_reg(3'd0, 8'h33);
      cyc(DEC_NONE, DEC_NONE, 3'd0, MUX_ZERO, ALU_BUSA, 1'b1, 1'b0, 2'b00);
      n_tests++; if (busc !== 8'h33) begin n_fail++; $display("FAIL clrld_busc: got %h expected 33", busc); end
      cyc(3'd3, 3'd3, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
      cyc(3'd0, 3'd1, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
      cyc(DEC_NONE, 3'b100, MUX_ZERO, MUX_ZERO, ALU_BUSA, 1'b1, 1'b1, 2'b00);
      read_reg(3'd3, v);
      n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL same_reg_clear_wins: got %h expected 00", v); end
      read_reg(3'd0, v);
      n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL diff_reg_clear: got %h expected 00", v); end
      read_reg(3'd1, v);
      n_tests++; if (v !== 8'h33) begin n_fail++; $display("FAIL diff_reg_load: got %h expected 33", v); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_fix_shift();
      test_add_flags();
      test_sub_dec();
      test_logic();
      test_shift();
      test_clr_ld();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sc_datapath.md
Name: sc_datapath

Overview:
Datapath that executes the control words issued by the SC_STATEMACHINE control unit.
- Contains 4 general registers (GenREG_0..3) and 2 fixed registers (RegFIX_0/1).
- BUSA/BUSB read muxes feed a combinational ALU, which feeds a shift register (REGSHIFTER). The shift register output is BUSC.
- Returns active-low status flags (overflow, carry, negative, zero) to the control unit for branching.

Parameters:
DATAWIDTH_BUS, 8, width of all registers, buses and the ALU.
DATAWIDTH_DECODER_SELECTION, 3, clear/load decoder select width.
DATAWIDTH_MUX_SELECTION, 3, BUSA/BUSB mux select width.
DATAWIDTH_ALU_SELECTION, 4, ALU opcode width.
DATAWIDTH_REGSHIFTER_SELECTION, 2, shifter control width.
DATA_FIXED_REGFIX0, 8'd0, constant value of RegFIX_0.
DATA_FIXED_REGFIX1, 8'd1, constant value of RegFIX_1.

Ports:
SC_DATAPATH_CLOCK_50  in  1  system clock; all state updates on rising edge.
SC_DATAPATH_RESET_InHigh  in  1  reset; asynchronous, active-high.
SC_DATAPATH_decoderclearselection_InBUS  in  3  000-011 clear GenREG_n; other codes: none.
SC_DATAPATH_decoderloadselection_InBUS  in  3  000-011 load GenREG_n from BUSC; other codes: none.
SC_DATAPATH_muxselectionBUSA_InBUS  in  3  BUSA source select.
SC_DATAPATH_muxselectionBUSB_InBUS  in  3  BUSB source select.
SC_DATAPATH_aluselection_InBUS  in  4  ALU opcode.
SC_DATAPATH_regSHIFTERclear_InLow  in  1  0 = clear shifter.
SC_DATAPATH_regSHIFTERload_InLow  in  1  0 = load shifter from ALU result.
SC_DATAPATH_regSHIFTERshiftselection_InLow  in  2  01 shift left; 10 shift right; 00/11 hold.
SC_DATAPATH_BUSC_OutBUS  out  8  shifter contents (BUSC).
SC_DATAPATH_overflow_OutLow  out  1  registered flag; 0 = signed overflow.
SC_DATAPATH_carry_OutLow  out  1  registered flag; 0 = carry out.
SC_DATAPATH_negative_OutLow  out  1  registered flag; 0 = result MSB set.
SC_DATAPATH_zero_OutLow  out  1  registered flag; 0 = result is zero.

Behaviour:
- Reset (async, active-high): GenREG_0..3 = 0, shifter = 0, all flag outputs = 1 (inactive). RegFIX values are constants and unaffected.
- Read muxes (combinational), codes:
  - 000-011 = GenREG_0..3
  - 100 = RegFIX_0
  - 101 = RegFIX_1
  - 110/111 = 0
- ALU (combinational, 8-bit result R), opcodes:
  - 0000 A; 0001 A|B; 0010 A&B; 0011 ~A; 0100 A^B; 0101-0111 A
  - 1000 A+B; 1001 A-B (computed as A+~B+1); 1010 A+1; 1011 A-1 (computed as A+8'hFF)
  - 1100-1111 A
- Carry = bit 8 of the 9-bit sum; for SUB this is 1 when A >= B unsigned.
- Overflow = signed two's-complement overflow of the add/sub.
- Logic and pass-through ops: carry = 0, overflow = 0.
- Shifter, one action per rising edge, priority clear > load > shift > hold:
  - clear_InLow = 0: shifter <= 0.
  - load_InLow = 0: shifter <= R.
  - 01: shifter <= {shifter[6:0], 0}.
  - 10: shifter <= {0, shifter[7:1]}.
  - Shifted-out bit is discarded; no wrap-around.
- Flags update only on a cycle with load_InLow = 0 and clear_InLow = 1, captured from R and the ALU carry/overflow, all inverted. Otherwise flags hold; a shifter clear does not change flags.
- General registers, per rising edge, evaluated independently for each n:
  - Clear select = n: GenREG_n <= 0.
  - Else load select = n: GenREG_n <= BUSC, i.e. the shifter value before this edge.
  - Clear and load on the same register in the same cycle: clear wins.
  - Clear and load on different registers in the same cycle: both act.
- Latency:
  - Read→ALU→shifter: 1 cycle.
  - Shifter→GenREG via load: 1 further cycle.
  - A register loaded at edge k is visible on BUSA/BUSB from edge k onward.
- Writing to RegFIX is impossible; load codes 100-111 do nothing.
- Reset asserted mid-sequence returns all state to reset values immediately, with no clock needed.

Decomposition:
- Package sc_datapath_pkg holds:
  - ALU opcode constants (ALU_BUSA, ALU_OR, ALU_AND, ALU_NOTA, ALU_XOR, ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC).
  - Mux source codes.
  - Decoder NONE code 3'b111.
  - Shift codes SHIFT_LEFT = 2'b01, SHIFT_RIGHT = 2'b10.
- Sub-module sc_datapath_alu: purely combinational, outputs R, carry and overflow.

Test Plan:
- Reset while shifter = 8'hAA and GenREG_1 = 8'h05 → all zero and flags = 1111 immediately, before any clock edge.
- RegFIX_1-to-GenREG_2 shift sequence: cycle 1 muxA = 101, alu = 0000; cycle 2 load_InLow = 0; cycle 3 shift = 01; cycle 4 loadsel = 010 → BUSC 1 then 2, GenREG_2 = 8'h02, zero_OutLow = 1 (set by the load in cycle 2).
- GenREG_0 = 8'h7F, GenREG_1 = 8'h01, ADD with shifter load → BUSC = 8'h80, overflow_OutLow = 0, negative_OutLow = 0, carry_OutLow = 1, zero_OutLow = 1.
- GenREG_0 = 8'h05, SUB with A = B = GenREG_0 → BUSC = 0, zero_OutLow = 0, carry_OutLow = 0; DEC on a zero register → 8'hFF, carry_OutLow = 1.
- Shifter = 8'h81: shift right → 8'h40; shift left twice from 8'h81 → 8'h04; load_InLow = 0 and shift = 01 in the same cycle → load wins.
- clearsel = loadsel = 011 in the same cycle with BUSC = 8'h33 → GenREG_3 = 0; clearsel = 000 with loadsel = 001 → GenREG_0 = 0 and GenREG_1 = 8'h33.
